// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op codes, FSM states and default widths for stack_ctrl
//
// Purpose: definitions common to stack_ctrl and stack_ptr.
//   OP_*       : 3-bit op codes presented on i_op
//   state_t    : sequencer states (ST_IDLE accepts ops, ST_FILL waits on memory)
//   *_DEFAULT  : default data/address widths and spill capacity
package stack_pkg;

  localparam int DW_DEFAULT        = 16;
  localparam int AW_DEFAULT        = 16;
  localparam int MEM_WORDS_DEFAULT = 65536;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_REPL = 3'b011;
  localparam logic [2:0] OP_SWAP = 3'b100;
  localparam logic [2:0] OP_DUP  = 3'b101;
  localparam logic [2:0] OP_OVER = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

endpackage

// File: rtl/stack_ptr.sv
// rtl/stack_ptr.sv - stack pointer and depth counters for stack_ctrl
//
// Purpose: owns sp (next free memory slot, grows downward) and the live-entry
// depth count. Both are updated from one-hot-style inc/dec strobes; with no
// strobe the value holds.
// Ports:
//   i_clock, i_reset_n        : clock, asynchronous active-low reset
//   i_sp_inc / i_sp_dec       : sp +1 (fill) / sp -1 (spill), modulo 2^AW
//   i_depth_inc / i_depth_dec : depth +1 / -1, saturating at full / empty
//   o_sp, o_sp_up             : current sp and sp+1 (address of the newest spill)
//   o_depth                   : live entry count
//   o_full, o_empty           : depth == MEM_WORDS+2, depth == 0
module stack_ptr
  import stack_pkg::*;
#(
  parameter int              AW        = AW_DEFAULT,
  parameter logic [AW-1:0]   SP_RESET  = 16'hFFFF,
  parameter int              MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_sp_inc,
  input  logic          i_sp_dec,
  input  logic          i_depth_inc,
  input  logic          i_depth_dec,
  output logic [AW-1:0] o_sp,
  output logic [AW-1:0] o_sp_up,
  output logic [AW+1:0] o_depth,
  output logic          o_full,
  output logic          o_empty
);

  // Two register entries (T, N) on top of the spill capacity.
  localparam logic [AW+1:0] DEPTH_FULL = (AW+2)'(MEM_WORDS + 2);
  localparam logic [AW-1:0] SP_ONE     = AW'(1);
  localparam logic [AW+1:0] DEPTH_ONE  = (AW+2)'(1);

  logic [AW-1:0] sp_q;
  logic [AW+1:0] depth_q;

  assign o_sp    = sp_q;
  assign o_sp_up = sp_q + SP_ONE;
  assign o_depth = depth_q;
  assign o_full  = (depth_q == DEPTH_FULL);
  assign o_empty = (depth_q == '0);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sp_q <= SP_RESET;
    end else if (i_sp_inc) begin
      sp_q <= sp_q + SP_ONE;
    end else if (i_sp_dec) begin
      sp_q <= sp_q - SP_ONE;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      depth_q <= '0;
    end else if (i_depth_inc && !o_full) begin
      depth_q <= depth_q + DEPTH_ONE;
    end else if (i_depth_dec && !o_empty) begin
      depth_q <= depth_q - DEPTH_ONE;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - data stack sequencer with T/N registers and memory spill/fill
//
// Purpose: keeps the top two stack entries in registers (T, N) and spills or
// fills deeper entries to a single-port, synchronous-read stack memory. The
// stack grows downward from SP_RESET; the oldest spill sits at the highest
// address.
// Optional feature: define STACK_CTRL_BOUNDS_EN to reject overflowing or
// underflowing ops (accepted, no effect) and raise the sticky o_err flag.
// Ports:
//   i_clock, i_reset_n   : clock, asynchronous active-low reset
//   i_valid, i_op, i_data: op request (see stack_pkg OP_*) and operand
//   o_ready              : op accepted on a rising edge when i_valid && o_ready
//   o_tos, o_nos, o_depth: T, N and live entry count
//   o_mem_*              : stack memory address, write strobe, write data
//   i_mem_rdata          : memory read data, valid the cycle after the address
//   o_err                : sticky bounds error (0 without the optional feature)
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int            DW        = DW_DEFAULT,
  parameter int            AW        = AW_DEFAULT,
  parameter logic [AW-1:0] SP_RESET  = 16'hFFFF,
  parameter int            MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_valid,
  input  logic [2:0]    i_op,
  input  logic [DW-1:0] i_data,
  output logic          o_ready,
  output logic [DW-1:0] o_tos,
  output logic [DW-1:0] o_nos,
  output logic [AW+1:0] o_depth,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_err
);

  localparam logic [AW+1:0] DEPTH_TWO = (AW+2)'(2);

  state_t        state_q, state_d;
  logic [DW-1:0] tos_q, tos_d;
  logic [DW-1:0] nos_q, nos_d;
  logic [DW-1:0] push_val;

  logic [AW-1:0] sp, sp_up;
  logic [AW+1:0] depth;
  logic          full, empty;
  logic          depth_ge2, depth_gt2;
  logic          sp_inc, sp_dec, depth_inc, depth_dec;

  logic          push_bad, pop_bad, swap_bad;
  logic          err_set;
  logic          mem_we;
  logic [AW-1:0] mem_addr;

  stack_ptr #(
    .AW        (AW),
    .SP_RESET  (SP_RESET),
    .MEM_WORDS (MEM_WORDS)
  ) u_ptr (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_sp_inc    (sp_inc),
    .i_sp_dec    (sp_dec),
    .i_depth_inc (depth_inc),
    .i_depth_dec (depth_dec),
    .o_sp        (sp),
    .o_sp_up     (sp_up),
    .o_depth     (depth),
    .o_full      (full),
    .o_empty     (empty)
  );

  assign depth_ge2 = (depth >= DEPTH_TWO);
  assign depth_gt2 = (depth >  DEPTH_TWO);

`ifdef STACK_CTRL_BOUNDS_EN
  assign push_bad = full
                 || ((i_op == OP_DUP)  && empty)
                 || ((i_op == OP_OVER) && !depth_ge2);
  assign pop_bad  = empty;
  assign swap_bad = !depth_ge2;
`else
  assign push_bad = 1'b0;
  assign pop_bad  = 1'b0;
  assign swap_bad = 1'b0;
`endif

  // DUP and OVER are PUSH with the operand taken from T or N.
  always_comb begin
    push_val = i_data;
    case (i_op)
      OP_DUP:  push_val = tos_q;
      OP_OVER: push_val = nos_q;
      default: push_val = i_data;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    tos_d     = tos_q;
    nos_d     = nos_q;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    depth_inc = 1'b0;
    depth_dec = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = sp;
    err_set   = 1'b0;

    if (state_q == ST_FILL) begin
      // Read was issued in the accept cycle; data lands now.
      nos_d   = i_mem_rdata;
      state_d = ST_IDLE;
    end else if (i_valid) begin
      case (i_op)
        OP_PUSH, OP_DUP, OP_OVER: begin
          if (push_bad) begin
            err_set = 1'b1;
          end else begin
            tos_d     = push_val;
            nos_d     = tos_q;
            depth_inc = 1'b1;
            // N only has somewhere to go once both registers are live.
            if (depth_ge2) begin
              mem_we = 1'b1;
              sp_dec = 1'b1;
            end
          end
        end
        OP_POP: begin
          if (pop_bad) begin
            err_set = 1'b1;
          end else begin
            tos_d     = nos_q;
            depth_dec = 1'b1;
            if (depth_gt2) begin
              mem_addr = sp_up;
              sp_inc   = 1'b1;
              state_d  = ST_FILL;
            end else begin
              nos_d = '0;
            end
          end
        end
        OP_REPL: begin
          tos_d = i_data;
        end
        OP_SWAP: begin
          if (swap_bad) begin
            err_set = 1'b1;
          end else begin
            tos_d = nos_q;
            nos_d = tos_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tos_q <= '0;
      nos_q <= '0;
    end else begin
      tos_q <= tos_d;
      nos_q <= nos_d;
    end
  end

`ifdef STACK_CTRL_BOUNDS_EN
  logic err_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  logic unused_bounds;
  assign unused_bounds = full | empty | err_set;
  assign o_err         = 1'b0;
`endif

  assign o_ready     = (state_q == ST_IDLE);
  assign o_tos       = tos_q;
  assign o_nos       = nos_q;
  assign o_depth     = depth;
  assign o_mem_addr  = mem_addr;
  assign o_mem_we    = mem_we;
  assign o_mem_wdata = mem_we ? nos_q : '0;

endmodule
